// File: rtl/switch_pio_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pio_irq_pkg
//  Description : Shared register offsets, edge-mode codes and helpers for the
//                switch_pio_irq input PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pio_irq_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : switch_pio_irq_pkg
`default_nettype wire

// File: rtl/switch_pio_irq_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pio_irq_if
//  Description : Avalon-MM slave bus bundle for the switch_pio_irq PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_pio_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface : switch_pio_irq_if
`default_nettype wire

// File: rtl/switch_pio_irq_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pio_debounce_bit
//  Description : Two-flop synchroniser followed by a stability counter for a
//                single asynchronous input bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit
    import switch_pio_irq_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_BIT       = 1'b0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_bit,
    output logic      o_stable
);

    localparam int c_cnt_w = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);

    logic sync1_q;
    logic sync2_q;
    logic stable_q;
    logic stable_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= RESET_BIT;
            sync2_q  <= RESET_BIT;
            stable_q <= RESET_BIT;
        end else begin
            sync1_q  <= i_bit;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

            logic [c_cnt_w-1:0] cnt_q;
            logic [c_cnt_w-1:0] cnt_d;

            // Any cycle where the synchronised input agrees with stable restarts the count.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync2_q != stable_q) begin
                    if (cnt_q == c_cnt_last) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_debounce
            always_comb begin
                stable_d = sync2_q;
            end
        end
    endgenerate

    assign o_stable = stable_q;

endmodule : pio_debounce_bit
`default_nettype wire

// File: rtl/switch_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pio_irq
//  Description : Avalon-MM input PIO with debounce, per-bit edge capture
//                (write-1-to-clear), interrupt mask and level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_pio_irq
    import switch_pio_irq_pkg::*;
#(
    parameter int               WIDTH           = 18,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    switch_pio_irq_if.slave       bus,
    input  wire logic [WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_event;
    logic             w_wr;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VALUE[i])
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .i_bit    (in_port[i]),
                .o_stable (w_stable[i])
            );
        end

        if (WIDTH < 32) begin : g_wdata_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISING:  w_event = w_stable & ~prev_q;
            EDGE_FALLING: w_event = ~w_stable & prev_q;
            default:      w_event = w_stable ^ prev_q;
        endcase
    end

    assign w_wr = bus.chipselect & ~bus.write_n;

    always_comb begin
        prev_d    = w_stable;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;

        if (w_wr && (bus.address == ADDR_IRQMASK)) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end
        if (w_wr && (bus.address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~bus.writedata[WIDTH-1:0];
        end
        // Applied after the clear so a coincident event is never lost.
        edgecap_d = edgecap_d | w_event;

        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= RESET_VALUE;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq          = |(edgecap_q & irqmask_q);
    assign bus.readdata = readdata_q;

endmodule : switch_pio_irq
`default_nettype wire

// File: tb/tb_switch_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_pio_irq
//  Description : Self-checking bench for switch_pio_irq; three instances cover
//                any-edge, rising-only and falling-only capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_pio_irq;

    localparam int WIDTH = 18;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic             irq_any;
    logic             irq_rise;
    logic             irq_fall;

    int n_tests;
    int n_fail;

    typedef struct {
        string       tag;
        logic [31:0] exp_any;
        logic [31:0] exp_rise;
        logic [31:0] exp_fall;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    switch_pio_irq_if bus_any ();
    switch_pio_irq_if bus_rise ();
    switch_pio_irq_if bus_fall ();

    assign bus_any.address     = address;
    assign bus_any.chipselect  = chipselect;
    assign bus_any.write_n     = write_n;
    assign bus_any.writedata   = writedata;
    assign bus_rise.address    = address;
    assign bus_rise.chipselect = chipselect;
    assign bus_rise.write_n    = write_n;
    assign bus_rise.writedata  = writedata;
    assign bus_fall.address    = address;
    assign bus_fall.chipselect = chipselect;
    assign bus_fall.write_n    = write_n;
    assign bus_fall.writedata  = writedata;

    switch_pio_irq #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut (
        .clk (clk), .reset (reset), .bus (bus_any.slave), .in_port (in_port), .irq (irq_any)
    );
    switch_pio_irq #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
        .clk (clk), .reset (reset), .bus (bus_rise.slave), .in_port (in_port), .irq (irq_rise)
    );
    switch_pio_irq #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_fall (
        .clk (clk), .reset (reset), .bus (bus_fall.slave), .in_port (in_port), .irq (irq_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Writes land on the posedge following the call.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic issue_read(input logic [1:0] a, input string tag,
                              input logic [31:0] ea, input logic [31:0] er, input logic [31:0] ef);
        rd_exp_t e;
        e.tag      = tag;
        e.exp_any  = ea;
        e.exp_rise = er;
        e.exp_fall = ef;
        sb_q.push_back(e);
        address = a;
    endtask

    task automatic collect_read();
        rd_exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue required pending read");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_any"},  bus_any.readdata,  e.exp_any);
            check({e.tag, "_rise"}, bus_rise.readdata, e.exp_rise);
            check({e.tag, "_fall"}, bus_fall.readdata, e.exp_fall);
        end
    endtask

    task automatic do_read(input logic [1:0] a, input string tag,
                           input logic [31:0] ea, input logic [31:0] er, input logic [31:0] ef);
        issue_read(a, tag, ea, er, ef);
        @(negedge clk);
        collect_read();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        cycles(3);
        reset = 1'b0;

        check("reset_readdata", bus_any.readdata, 32'h0);
        check("reset_irq", {31'd0, irq_any}, 32'h0);
        do_read(2'd0, "data_zero", 32'h0, 32'h0, 32'h0);

        in_port = 18'h3FFFF;
        cycles(10);
        do_read(2'd0, "data_ones", 32'h0003FFFF, 32'h0003FFFF, 32'h0003FFFF);
        do_read(2'd1, "rsvd", 32'h0, 32'h0, 32'h0);
        do_read(2'd3, "cap_rise_all", 32'h0003FFFF, 32'h0003FFFF, 32'h0);

        in_port = 18'h0;
        cycles(10);
        do_read(2'd3, "cap_fall_all", 32'h0003FFFF, 32'h0003FFFF, 32'h0003FFFF);
        bus_write(2'd3, 32'h0003FFFF);
        do_read(2'd3, "cap_cleared", 32'h0, 32'h0, 32'h0);

        // Three-cycle glitch must be swallowed by the debouncer.
        in_port = 18'h1;
        cycles(3);
        in_port = 18'h0;
        cycles(10);
        do_read(2'd0, "glitch_data", 32'h0, 32'h0, 32'h0);
        do_read(2'd3, "glitch_cap", 32'h0, 32'h0, 32'h0);

        bus_write(2'd2, 32'h1);
        do_read(2'd2, "mask_rd", 32'h1, 32'h1, 32'h1);

        // Edge-accurate latency: stable at edge 5, capture at edge 6.
        address = 2'd0;
        in_port = 18'h1;
        for (int k = 0; k <= 6; k++) begin
            issue_read(2'd0, $sformatf("lat_data_e%0d", k),
                       (k >= 6) ? 32'h1 : 32'h0, (k >= 6) ? 32'h1 : 32'h0, (k >= 6) ? 32'h1 : 32'h0);
            @(negedge clk);
            collect_read();
            check($sformatf("lat_irq_e%0d", k), {31'd0, irq_any}, (k >= 6) ? 32'h1 : 32'h0);
        end

        bus_write(2'd2, 32'h0);
        check("irq_masked", {31'd0, irq_any}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("irq_unmask", {31'd0, irq_any}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_w1c", {31'd0, irq_any}, 32'h0);
        do_read(2'd3, "cap_w1c", 32'h0, 32'h0, 32'h0);

        bus_write(2'd2, 32'h20);
        in_port = 18'h9;
        cycles(10);
        check("irq_other_mask", {31'd0, irq_any}, 32'h0);
        do_read(2'd3, "cap_bit3", 32'h8, 32'h8, 32'h0);
        bus_write(2'd3, 32'h8);

        // Clear lands on the same edge that captures the bit0 fall.
        in_port = 18'h8;
        cycles(6);
        bus_write(2'd3, 32'h1);
        do_read(2'd3, "set_wins", 32'h1, 32'h0, 32'h1);

        in_port = 18'h0;
        cycles(10);
        bus_write(2'd3, 32'h0003FFFF);
        in_port = 18'h4;
        cycles(10);
        do_read(2'd3, "mode_rise", 32'h4, 32'h4, 32'h0);
        bus_write(2'd3, 32'h0003FFFF);
        in_port = 18'h0;
        cycles(10);
        do_read(2'd3, "mode_fall", 32'h4, 32'h0, 32'h4);
        bus_write(2'd3, 32'h0003FFFF);

        in_port = 18'h3;
        cycles(10);
        bus_write(2'd2, 32'h3);
        check("irq_pre_reset", {31'd0, irq_any}, 32'h1);
        in_port = 18'h0;
        cycles(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("irq_post_reset", {31'd0, irq_any}, 32'h0);
        check("rd_post_reset", bus_any.readdata, 32'h0);
        do_read(2'd3, "cap_post_reset", 32'h0, 32'h0, 32'h0);
        do_read(2'd2, "mask_post_reset", 32'h0, 32'h0, 32'h0);
        do_read(2'd0, "data_post_reset", 32'h0, 32'h0, 32'h0);

        in_port = 18'h2A5A5;
        cycles(10);
        bus_write(2'd0, 32'h0);
        do_read(2'd0, "data_ro", 32'h0002A5A5, 32'h0002A5A5, 32'h0002A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_switch_pio_irq
`default_nettype wire
